// File: rtl/dfu_boot_helper.sv
`default_nettype none
// ============================================================================
// Module : dfu_boot_helper
// Brief  : Button debounce/press classifier and iCE40 warm-boot sequencer.
// Rev    : 1.0
// ============================================================================
module dfu_boot_helper #(
    parameter int TIMER_WIDTH = 24,
    parameter int BTN_MODE    = 3,
    parameter int DFU_MODE    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       boot_now,
    input  logic [1:0] boot_sel,
    input  logic       btn_pad,
    output logic       btn_val,
    output logic       rst_req,
    output logic       wb_boot,
    output logic [1:0] wb_sel
);

    localparam logic       c_pad_idle = (BTN_MODE == 1) ? 1'b0 : 1'b1;
    localparam logic [1:0] c_img_dfu  = 2'b01;
    localparam logic [1:0] c_img_app  = 2'b10;
    localparam logic [TIMER_WIDTH-1:0] c_timer_one = {{(TIMER_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_BOOT = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [1:0]             r_sync;
    logic [3:0]             r_db_cnt;
    logic                   r_btn_val;
    logic                   r_btn_prev;
    logic [TIMER_WIDTH-1:0] r_timer;
    logic                   r_long_prev;
    logic                   r_boot_now_q;
    logic                   r_rst_req;
    logic                   r_wb_boot;
    logic [1:0]             r_wb_sel;

    logic                   w_btn_norm;
    logic                   w_long;
    logic                   w_release;
    logic                   w_long_rise;
    logic                   w_sw_edge;
    logic                   w_btn_boot;
    logic                   w_btn_rst;
    logic [1:0]             w_btn_img;
    logic [1:0]             w_sel_nxt;
    logic                   w_rst_req_nxt;

    always_comb begin
        w_btn_norm = 1'b0;
        if (BTN_MODE == 1) begin
            w_btn_norm = r_sync[1];
        end else if (BTN_MODE != 0) begin
            w_btn_norm = ~r_sync[1];
        end
    end

    // Synchronizer resets to the idle pad level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync     <= {2{c_pad_idle}};
            r_db_cnt   <= 4'd0;
            r_btn_val  <= 1'b0;
            r_btn_prev <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], btn_pad};
            r_btn_prev <= r_btn_val;
            if (w_btn_norm == r_btn_val) begin
                r_db_cnt <= 4'd0;
            end else if (r_db_cnt == 4'hF) begin
                r_db_cnt  <= 4'd0;
                r_btn_val <= ~r_btn_val;
            end else begin
                r_db_cnt <= r_db_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer     <= '0;
            r_long_prev <= 1'b0;
        end else begin
            if (!r_btn_val) begin
                r_timer <= '0;
            end else if (!r_timer[TIMER_WIDTH-1]) begin
                r_timer <= r_timer + c_timer_one;
            end
            r_long_prev <= r_timer[TIMER_WIDTH-1];
        end
    end

    assign w_long      = r_timer[TIMER_WIDTH-1];
    assign w_release   = r_btn_prev & ~r_btn_val;
    assign w_long_rise = w_long & ~r_long_prev;
    assign w_sw_edge   = boot_now & ~r_boot_now_q;

    // Timer still holds the press length in the release cycle; it clears one clock later.
    always_comb begin
        if (DFU_MODE == 0) begin
            w_btn_boot = w_long_rise;
            w_btn_img  = c_img_dfu;
            w_btn_rst  = w_release & ~w_long;
        end else begin
            w_btn_boot = w_release;
            w_btn_img  = c_img_app;
            w_btn_rst  = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_wb_sel;
        w_rst_req_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sw_edge) begin
                    w_state_nxt = ST_ARM;
                    w_sel_nxt   = boot_sel;
                end else if (w_btn_boot) begin
                    w_state_nxt = ST_ARM;
                    w_sel_nxt   = w_btn_img;
                end else begin
                    w_rst_req_nxt = w_btn_rst;
                end
            end
            ST_ARM:  w_state_nxt = ST_BOOT;
            ST_BOOT: w_state_nxt = ST_BOOT;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_wb_sel     <= 2'b00;
            r_wb_boot    <= 1'b0;
            r_rst_req    <= 1'b0;
            r_boot_now_q <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wb_sel     <= w_sel_nxt;
            r_wb_boot    <= (w_state_nxt == ST_BOOT);
            r_rst_req    <= w_rst_req_nxt;
            r_boot_now_q <= boot_now;
        end
    end

    assign btn_val = r_btn_val;
    assign rst_req = r_rst_req;
    assign wb_boot = r_wb_boot;
    assign wb_sel  = r_wb_sel;

endmodule
`default_nettype wire

// File: tb/tb_dfu_boot_helper.sv
`default_nettype none
// ============================================================================
// Module : tb_dfu_boot_helper
// Brief  : Scoreboard bench over four build configurations sharing one stimulus.
// Rev    : 1.0
// ============================================================================
module tb_dfu_boot_helper;

    localparam int c_tw   = 8;
    localparam int c_long = 1 << (c_tw - 1);
    localparam int c_n    = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       boot_now;
    logic [1:0] boot_sel;
    logic       btn_pad;
    logic [3:0] bv_o;
    logic [3:0] rr_o;
    logic [3:0] wbb_o;
    logic [7:0] wbs_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    // Instance g: BTN_MODE/DFU_MODE = 0:(3,0) 1:(3,1) 2:(1,0) 3:(0,1)
    for (genvar g = 0; g < c_n; g++) begin : g_dut
        dfu_boot_helper #(
            .TIMER_WIDTH(c_tw),
            .BTN_MODE   ((g == 2) ? 1 : ((g == 3) ? 0 : 3)),
            .DFU_MODE   (g % 2)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .boot_now(boot_now),
            .boot_sel(boot_sel),
            .btn_pad (btn_pad),
            .btn_val (bv_o[g]),
            .rst_req (rr_o[g]),
            .wb_boot (wbb_o[g]),
            .wb_sel  (wbs_o[2*g +: 2])
        );
    end

    function automatic int mode_of(input int g);
        return (g == 2) ? 1 : ((g == 3) ? 0 : 3);
    endfunction

    function automatic int dfu_of(input int g);
        return g % 2;
    endfunction

    function automatic bit norm(input int g, input bit p);
        if (mode_of(g) == 0) return 1'b0;
        if (mode_of(g) == 1) return p;
        return !p;
    endfunction

    typedef struct {
        int       dis;
        bit       bv;
        int       t_rise;
        int       t_fall;
        bit       booted;
        int       arm;
        bit [1:0] sel;
        bit       bn_prev;
        bit       h0;
        bit       h1;
    } mdl_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  bv;
        logic [3:0]  rr;
        logic [3:0]  wbb;
        logic [7:0]  sel;
    } exp_t;

    mdl_t m [c_n];
    exp_t q [$];
    exp_t e;

    task automatic chk(input string nm, input int g, input int c,
                       input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut=%0d cyc=%0d actual=%0h expected=%0h", nm, g, c, act, exp);
        end
    endtask

    // Reference model: press/release time stamps drive the actions; debounced
    // level follows the input delayed by two clocks once it disagrees 16 times in a row.
    initial begin : p_model
        bit       rel, lng, lrise, sw, act_boot, act_rst, rr, samp;
        bit [1:0] img;
        exp_t     x;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                cyc = 0;
                for (int g = 0; g < c_n; g++) begin
                    m[g].dis     = 0;
                    m[g].bv      = 1'b0;
                    m[g].t_rise  = -1;
                    m[g].t_fall  = -1;
                    m[g].booted  = 1'b0;
                    m[g].arm     = 0;
                    m[g].sel     = 2'b00;
                    m[g].bn_prev = 1'b0;
                    m[g].h0      = (mode_of(g) == 1) ? 1'b0 : 1'b1;
                    m[g].h1      = m[g].h0;
                end
            end else begin
                cyc++;
                x     = '0;
                x.cyc = cyc;
                for (int g = 0; g < c_n; g++) begin
                    rel   = (m[g].t_fall == cyc - 1);
                    lng   = (m[g].t_fall - m[g].t_rise) >= c_long;
                    lrise = (m[g].t_rise >= 0) && (cyc == m[g].t_rise + c_long + 1) &&
                            ((m[g].t_fall < m[g].t_rise) || (m[g].t_fall >= m[g].t_rise + c_long));
                    sw    = boot_now && !m[g].bn_prev;
                    if (dfu_of(g) == 1) begin
                        act_boot = rel;   img = 2'b10; act_rst = 1'b0;
                    end else begin
                        act_boot = lrise; img = 2'b01; act_rst = rel && !lng;
                    end
                    rr = 1'b0;
                    if (!m[g].booted) begin
                        if (sw) begin
                            m[g].booted = 1'b1; m[g].arm = cyc; m[g].sel = boot_sel;
                        end else if (act_boot) begin
                            m[g].booted = 1'b1; m[g].arm = cyc; m[g].sel = img;
                        end else begin
                            rr = act_rst;
                        end
                    end
                    samp    = norm(g, m[g].h0);
                    m[g].h0 = m[g].h1;
                    m[g].h1 = btn_pad;
                    if (samp != m[g].bv) begin
                        m[g].dis++;
                        if (m[g].dis == 16) begin
                            m[g].dis = 0;
                            m[g].bv  = !m[g].bv;
                            if (m[g].bv) m[g].t_rise = cyc;
                            else         m[g].t_fall = cyc;
                        end
                    end else begin
                        m[g].dis = 0;
                    end
                    m[g].bn_prev = boot_now;
                    x.bv[g]         = m[g].bv;
                    x.rr[g]         = rr;
                    x.wbb[g]        = m[g].booted && (cyc > m[g].arm);
                    x.sel[2*g +: 2] = m[g].sel;
                end
                q.push_back(x);
            end
        end
    end

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            for (int g = 0; g < c_n; g++) begin
                chk("btn_val", g, e.cyc, {1'b0, bv_o[g]},  {1'b0, e.bv[g]});
                chk("rst_req", g, e.cyc, {1'b0, rr_o[g]},  {1'b0, e.rr[g]});
                chk("wb_boot", g, e.cyc, {1'b0, wbb_o[g]}, {1'b0, e.wbb[g]});
                chk("wb_sel",  g, e.cyc, wbs_o[2*g +: 2],  e.sel[2*g +: 2]);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input int len, input int gap);
        btn_pad = 1'b0;
        wait_cyc(len);
        btn_pad = 1'b1;
        wait_cyc(gap);
    endtask

    task automatic sw_boot(input logic [1:0] sel, input int hold);
        boot_sel = sel;
        boot_now = 1'b1;
        wait_cyc(1);
        boot_sel = 2'($urandom);
        wait_cyc(hold);
        boot_now = 1'b0;
        wait_cyc(4);
    endtask

    // Reset is asserted between edges so outputs must clear without a clock.
    task automatic do_reset;
        @(negedge clk);
        #1;
        rst_n    = 1'b0;
        boot_now = 1'b0;
        btn_pad  = 1'b1;
        #1;
        for (int g = 0; g < c_n; g++) begin
            chk("rst_btn_val", g, -1, {1'b0, bv_o[g]},  2'b00);
            chk("rst_rst_req", g, -1, {1'b0, rr_o[g]},  2'b00);
            chk("rst_wb_boot", g, -1, {1'b0, wbb_o[g]}, 2'b00);
            chk("rst_wb_sel",  g, -1, wbs_o[2*g +: 2],  2'b00);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin : p_stim
        int np;
        int k;
        int len;
        rst_n    = 1'b0;
        boot_now = 1'b0;
        boot_sel = 2'b00;
        btn_pad  = 1'b1;
        wait_cyc(2);
        do_reset();

        wait_cyc(10);
        sw_boot(2'b11, 20);
        wait_cyc(10);
        do_reset();

        press(60, 60);
        wait_cyc(20);
        do_reset();

        press(300, 40);
        do_reset();

        press(40, 60);
        do_reset();

        press(c_long, 60);
        do_reset();

        repeat (20) press(10, 10);
        wait_cyc(40);
        do_reset();

        for (int ep = 0; ep < 20; ep++) begin
            np = $urandom_range(1, 3);
            wait_cyc($urandom_range(5, 30));
            for (int p = 0; p < np; p++) begin
                k = $urandom_range(0, 2);
                if (k == 0)      len = $urandom_range(3, 15);
                else if (k == 1) len = $urandom_range(16, 125);
                else             len = $urandom_range(126, 260);
                if ($urandom_range(0, 5) == 0) sw_boot(2'($urandom), $urandom_range(1, 8));
                press(len, $urandom_range(20, 50));
            end
            wait_cyc(30);
            do_reset();
        end

        chk("scoreboard_drained", 0, cyc, {1'b0, q.size() == 0}, 2'b01);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
